// File: rtl/rsa_mod_exp_pkg.sv
// Shared types and defaults for the RSA modular-exponentiation engine.
package rsa_mod_exp_pkg;

   localparam int RSA_KEY_W = 256;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      R2       = 3'd1,
      TO_M     = 3'd2,
      TO_1     = 3'd3,
      LOOP_MUL = 3'd4,
      LOOP_SQR = 3'd5,
      FROM     = 3'd6,
      DONE     = 3'd7
   } rsa_exp_state_e;

endpackage

// File: rtl/rsa_mod_exp_mont.sv
// Bit-serial Montgomery multiplier: o_out = i_a * i_b * 2^-KEY_W mod i_n.
// Busy KEY_W+1 cycles after i_start; o_done/o_out are valid in the final cycle.
module rsa_mont_mul #(
   parameter int KEY_W = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [KEY_W-1:0] i_a,
   input  logic [KEY_W-1:0] i_b,
   input  logic [KEY_W-1:0] i_n,
   output logic             o_done,
   output logic [KEY_W-1:0] o_out
);

   localparam int IW = $clog2(KEY_W + 1);

   logic [KEY_W+1:0] r_acc;
   logic [KEY_W-1:0] r_a;
   logic [KEY_W-1:0] r_b;
   logic [KEY_W-1:0] r_n;
   logic [IW-1:0]    r_cnt;
   logic             r_busy;

   logic [KEY_W+1:0] w_sum1;
   logic [KEY_W+1:0] w_sum2;
   logic             w_last;
   logic             w_ge;

   // The accumulator stays below 2N, so r + b + N < 4N fits in KEY_W+2 bits.
   assign w_sum1 = r_acc + (r_a[0] ? {2'b00, r_b} : '0);
   assign w_sum2 = w_sum1 + (w_sum1[0] ? {2'b00, r_n} : '0);
   assign w_last = (r_cnt == IW'(KEY_W));
   assign w_ge   = (r_acc >= {2'b00, r_n});

   assign o_done = r_busy && w_last;
   assign o_out  = w_ge ? KEY_W'(r_acc - {2'b00, r_n}) : r_acc[KEY_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc  <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_n    <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_acc  <= '0;
         r_a    <= i_a;
         r_b    <= i_b;
         r_n    <= i_n;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (w_last) begin
            r_busy <= 1'b0;
         end else begin
            r_acc <= w_sum2 >> 1;
            r_a   <= r_a >> 1;
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rsa_mod_exp.sv
// RSA modular exponentiation o_crypto = i_msg^i_key mod i_modulus using
// an R^2 precompute and right-to-left square-and-multiply on one Montgomery unit.
module rsa_mod_exp
   import rsa_mod_exp_pkg::*;
#(
   parameter int KEY_W = RSA_KEY_W,
   parameter int CNT_W = $clog2(2 * KEY_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [KEY_W-1:0] i_msg,
   input  logic [KEY_W-1:0] i_key,
   input  logic [KEY_W-1:0] i_modulus,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [KEY_W-1:0] o_crypto,
   output rsa_exp_state_e   o_state
);

   localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

   rsa_exp_state_e r_state;
   rsa_exp_state_e w_next_state;

   logic [KEY_W-1:0] r_msg;
   logic [KEY_W-1:0] r_key;
   logic [KEY_W-1:0] r_n;
   logic [KEY_W-1:0] r_x;
   logic [KEY_W-1:0] r_base;
   logic [KEY_W-1:0] r_acc;
   logic [KEY_W-1:0] r_crypto;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_msb;
   logic             r_busy;

   logic             w_start;
   logic             w_done;
   logic [KEY_W-1:0] w_op_a;
   logic [KEY_W-1:0] w_op_b;
   logic [KEY_W-1:0] w_mont_out;
   logic [KEY_W:0]   w_dbl;
   logic             w_key_bit;
   logic             w_r2_last;
   logic             w_at_msb;

   function automatic logic [CNT_W-1:0] f_msb(input logic [KEY_W-1:0] k);
      f_msb = '0;
      for (int j = 0; j < KEY_W; j++) begin
         if (k[j]) f_msb = CNT_W'(j);
      end
   endfunction

   assign w_dbl     = {r_x, 1'b0};
   assign w_key_bit = r_key[r_cnt[IDX_W-1:0]];
   assign w_r2_last = (r_cnt == CNT_W'(2 * KEY_W - 1));
   assign w_at_msb  = (r_cnt == r_msb);

   assign i_ready  = (r_state == IDLE);
   assign o_valid  = (r_state == DONE);
   assign o_crypto = r_crypto;
   assign o_state  = r_state;

   rsa_mont_mul #(.KEY_W(KEY_W)) u_mont (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_a     (w_op_a),
      .i_b     (w_op_b),
      .i_n     (r_n),
      .o_done  (w_done),
      .o_out   (w_mont_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // A zero key bit costs nothing: its issue cycle launches the square directly.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_op_a       = r_msg;
      w_op_b       = r_x;
      case (r_state)
         IDLE: if (i_valid) w_next_state = R2;
         R2:   if (w_r2_last) w_next_state = TO_M;
         TO_M: begin
            w_start = !r_busy;
            if (w_done) w_next_state = TO_1;
         end
         TO_1: begin
            w_start = !r_busy;
            w_op_a  = r_x;
            w_op_b  = KEY_W'(1);
            if (w_done) w_next_state = (r_key == '0) ? FROM : LOOP_MUL;
         end
         LOOP_MUL: begin
            w_start = !r_busy;
            if (w_key_bit) begin
               w_op_a = r_acc;
               w_op_b = r_base;
            end else begin
               w_op_a = r_base;
               w_op_b = r_base;
            end
            if (!r_busy && !w_key_bit) w_next_state = LOOP_SQR;
            else if (w_done)           w_next_state = w_at_msb ? FROM : LOOP_SQR;
         end
         LOOP_SQR: begin
            w_start = !r_busy;
            w_op_a  = r_base;
            w_op_b  = r_base;
            if (w_done) w_next_state = LOOP_MUL;
         end
         FROM: begin
            w_start = !r_busy;
            w_op_a  = r_acc;
            w_op_b  = KEY_W'(1);
            if (w_done) w_next_state = DONE;
         end
         DONE: if (o_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msg    <= '0;
         r_key    <= '0;
         r_n      <= '0;
         r_x      <= '0;
         r_base   <= '0;
         r_acc    <= '0;
         r_crypto <= '0;
         r_cnt    <= '0;
         r_msb    <= '0;
         r_busy   <= 1'b0;
      end else begin
         if (w_start)     r_busy <= 1'b1;
         else if (w_done) r_busy <= 1'b0;

         case (r_state)
            IDLE: if (i_valid) begin
               r_msg <= i_msg;
               r_key <= i_key;
               r_n   <= i_modulus;
               r_msb <= f_msb(i_key);
               r_x   <= KEY_W'(1);
               r_cnt <= '0;
            end
            // r_x doubles 2*KEY_W times mod N, leaving R^2 mod N for the later conversions.
            R2: begin
               r_x   <= (w_dbl >= {1'b0, r_n}) ? KEY_W'(w_dbl - {1'b0, r_n})
                                               : w_dbl[KEY_W-1:0];
               r_cnt <= w_r2_last ? '0 : r_cnt + 1'b1;
            end
            TO_M:     if (w_done) r_base <= w_mont_out;
            TO_1:     if (w_done) r_acc  <= w_mont_out;
            LOOP_MUL: if (w_done) r_acc  <= w_mont_out;
            LOOP_SQR: if (w_done) begin
               r_base <= w_mont_out;
               r_cnt  <= r_cnt + 1'b1;
            end
            FROM:     if (w_done) r_crypto <= w_mont_out;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_mod_exp.sv
// Directed bench for rsa_mod_exp at KEY_W=8: vector table plus backpressure,
// DONE handshake overlap, mid-loop reset and even-modulus corner sequences.
module tb_rsa_mod_exp;
  import rsa_mod_exp_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_msg = '0;
  logic [W-1:0] i_key = '0;
  logic [W-1:0] i_modulus = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_crypto;
  rsa_exp_state_e o_state;

  int n_cmp  = 0;
  int n_fail = 0;

  rsa_mod_exp #(.KEY_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_msg     (i_msg),
    .i_key     (i_key),
    .i_modulus (i_modulus),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_crypto  (o_crypto),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] msg;
    logic [W-1:0] key;
    logic [W-1:0] n;
    logic [W-1:0] exp_res;
    int           exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accepts one job, drives random ignored traffic while busy, returns result and latency.
  task automatic do_job(input logic [W-1:0] m, input logic [W-1:0] k, input logic [W-1:0] n,
                        output logic [W-1:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!i_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    i_msg = m; i_key = k; i_modulus = n; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (lat < 1000) begin
      i_msg     = W'($urandom_range(0, 255));
      i_key     = W'($urandom_range(0, 255));
      i_modulus = W'($urandom_range(0, 255));
      i_valid   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (o_valid) break;
    end
    i_valid = 1'b0;
    res = o_crypto;
  endtask

  task automatic retire();
    @(negedge clk);
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    check("retire_valid_ready", 32'({o_valid, i_ready}), 32'(2'b01));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res;
    int           lat;

    vecs[0] = '{8'd88,  8'd7,   8'd187, 8'd11, 96};
    vecs[1] = '{8'd11,  8'd23,  8'd187, 8'd88, 126};
    vecs[2] = '{8'd5,   8'd0,   8'd187, 8'd1,  46};
    vecs[3] = '{8'd200, 8'd1,   8'd187, 8'd13, 56};
    vecs[4] = '{8'd0,   8'd5,   8'd187, 8'd0,  86};
    vecs[5] = '{8'd2,   8'd10,  8'd11,  8'd1,  96};
    vecs[6] = '{8'd3,   8'd250, 8'd251, 8'd1,  176};
    vecs[7] = '{8'd255, 8'd1,   8'd251, 8'd4,  56};
    vecs[8] = '{8'd7,   8'd2,   8'd13,  8'd10, 66};
    vecs[9] = '{8'd5,   8'd3,   8'd3,   8'd2,  76};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ready",  32'(i_ready),  32'd1);
    check("rst_o_valid",  32'(o_valid),  32'd0);
    check("rst_o_crypto", 32'(o_crypto), 32'd0);
    check("rst_state",    32'(o_state),  32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      do_job(vecs[v].msg, vecs[v].key, vecs[v].n, res, lat);
      check($sformatf("vec%0d_result", v),  32'(res), 32'(vecs[v].exp_res));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      retire();
    end

    // Backpressure: result held, no accept, input pulses ignored.
    do_job(8'd88, 8'd7, 8'd187, res, lat);
    check("bp_result", 32'(res), 32'd11);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      i_valid   = 1'($urandom_range(0, 1));
      i_msg     = W'($urandom_range(0, 255));
      i_key     = 8'd0;
      i_modulus = 8'd187;
      @(posedge clk); #1;
      check("bp_o_crypto", 32'(o_crypto), 32'd11);
      check("bp_valid_ready", 32'({o_valid, i_ready}), 32'(2'b10));
    end

    // o_ready and i_valid together in DONE: only the output retires.
    @(negedge clk);
    i_msg = 8'd5; i_key = 8'd0; i_modulus = 8'd187;
    i_valid = 1'b1; o_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; o_ready = 1'b0;
    check("overlap_valid_ready", 32'({o_valid, i_ready}), 32'(2'b01));
    repeat (3) @(posedge clk);
    #1;
    check("overlap_no_accept", 32'(o_state), 32'(IDLE));

    // Reset in the middle of the exponent loop.
    @(negedge clk);
    i_msg = 8'd88; i_key = 8'd23; i_modulus = 8'd187; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("mid_in_loop", 32'(o_state == LOOP_MUL || o_state == LOOP_SQR), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_i_ready",  32'(i_ready),  32'd1);
    check("mid_rst_o_valid",  32'(o_valid),  32'd0);
    check("mid_rst_o_crypto", 32'(o_crypto), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_job(8'd88, 8'd7, 8'd187, res, lat);
    check("post_rst_result",  32'(res), 32'd11);
    check("post_rst_latency", 32'(lat), 32'd96);
    retire();

    // Even modulus: value undefined, timing must still hold.
    do_job(8'd5, 8'd3, 8'd186, res, lat);
    check("even_n_latency", 32'(lat), 32'd76);
    retire();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
